keypad_scanner_16: RTL

//  Input-side counterpart of the 4-digit multiplexed 7-seg driver. It scans a 4x4 key matrix by driving
//  one active-low column at a time and reading four active-low rows. Each press is debounced into one
//  hex key event, and accepted digits are shifted into a 16-bit value that feeds the display's digit bus.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_debounce.sv | 163 ++++++++++++++++
 rtl/keypad_scanner_16.sv | 137 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The optional auto-repeat feature is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HELD    = 2'd2
  } kp_state_e;

  localparam int KEY_CODE_W          = 4;
  localparam int KEYPAD_REPEAT_SCANS = 32;
  localparam int REP_CNT_W           = 6;

  // A key is identified by its matrix position, row index in the upper bits.
  function automatic logic [KEY_CODE_W-1:0] key_encode(input logic [1:0] row_idx,
                                                       input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debouncer evaluated once per full matrix scan.
// With KEYPAD_REPEAT_EN defined, a held key re-emits its code every
// KEYPAD_REPEAT_SCANS scans.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scan_end_i,
  input  logic                  present_i,
  input  logic [KEY_CODE_W-1:0] code_i,
  output logic                  key_valid_o,
  output logic [KEY_CODE_W-1:0] key_code_o
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  kp_state_e             state_q, state_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            rel_cnt_q, rel_cnt_d;
  logic                  key_valid_q, key_valid_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  accept_s;
  logic                  repeat_s;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [REP_CNT_W-1:0] REP_N = REP_CNT_W'(KEYPAD_REPEAT_SCANS);
  logic [REP_CNT_W-1:0] rep_cnt_q, rep_cnt_d;

  // Repeat counter register: counts scans with the accepted key still down.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_cnt_q <= {REP_CNT_W{1'b0}};
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Repeat decision: only while HELD with the accepted code present.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    repeat_s  = 1'b0;
    if (scan_end_i) begin
      if ((state_q == HELD) && present_i && (code_i == cand_q)) begin
        if ((rep_cnt_q + {{(REP_CNT_W-1){1'b0}}, 1'b1}) == REP_N) begin
          repeat_s  = 1'b1;
          rep_cnt_d = {REP_CNT_W{1'b0}};
        end else begin
          rep_cnt_d = rep_cnt_q + {{(REP_CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        rep_cnt_d = {REP_CNT_W{1'b0}};
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  // State register plus registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cand_q      <= {KEY_CODE_W{1'b0}};
      cnt_q       <= 4'd0;
      rel_cnt_q   <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= {KEY_CODE_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  // Next-state logic; the FSM only moves on the scan-end strobe.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    rel_cnt_d = rel_cnt_q;
    accept_s  = 1'b0;
    if (scan_end_i) begin
      case (state_q)
        IDLE: begin
          if (present_i) begin
            cand_d    = code_i;
            cnt_d     = 4'd1;
            rel_cnt_d = 4'd0;
            if (DEB_N == 4'd1) begin
              state_d  = HELD;
              accept_s = 1'b1;
            end else begin
              state_d = PENDING;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PENDING: begin
          if (present_i) begin
            if (code_i == cand_q) begin
              cnt_d = cnt_q + 4'd1;
              if ((cnt_q + 4'd1) >= DEB_N) begin
                state_d   = HELD;
                accept_s  = 1'b1;
                rel_cnt_d = 4'd0;
              end else begin
                state_d = PENDING;
              end
            end else begin
              cand_d = code_i;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        HELD: begin
          if (present_i) begin
            rel_cnt_d = 4'd0;
          end else if ((rel_cnt_q + 4'd1) >= DEB_N) begin
            state_d   = IDLE;
            rel_cnt_d = 4'd0;
            cnt_d     = 4'd0;
          end else begin
            rel_cnt_d = rel_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = 4'd0;
          rel_cnt_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic: one-cycle pulse; the code only changes when a key is emitted.
  always_comb begin
    key_valid_d = accept_s | repeat_s;
    if (accept_s || repeat_s) begin
      key_code_d = code_i;
    end else begin
      key_code_d = key_code_q;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_scanner_16.sv
// 4x4 keypad scanner: column drive, row synchronizer, per-scan priority
// encode, debounce (keypad_debounce) and 4-digit value shift register.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner_16
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            row,
  input  logic                  clear,
  output logic [3:0]            col,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic [15:0]           value
);

  localparam logic [SCAN_DIV_W-1:0] DIV_MAX = {SCAN_DIV_W{1'b1}};
  localparam logic [SCAN_DIV_W-1:0] DIV_ONE = {{(SCAN_DIV_W-1){1'b0}}, 1'b1};

  logic [3:0]            row_meta_q, row_sync_q;
  logic [SCAN_DIV_W-1:0] div_q, div_d;
  logic [1:0]            col_idx_q, col_idx_d;
  logic [3:0]            col_q, col_d;
  logic                  acc_present_q, acc_present_d;
  logic [KEY_CODE_W-1:0] acc_code_q, acc_code_d;
  logic [15:0]           value_q, value_d;

  logic                  sample_s;
  logic                  scan_end_s;
  logic [3:0]            row_hit_s;
  logic [1:0]            row_idx_s;
  logic                  carry_present_s;
  logic                  present_s;
  logic [KEY_CODE_W-1:0] code_s;
  logic                  key_valid_s;
  logic [KEY_CODE_W-1:0] key_code_s;

  assign sample_s   = (div_q == DIV_MAX);
  assign scan_end_s = sample_s && (col_idx_q == 2'd3);

  // Row synchronizer and scan/value state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q    <= 4'b1111;
      row_sync_q    <= 4'b1111;
      div_q         <= {SCAN_DIV_W{1'b0}};
      col_idx_q     <= 2'd0;
      col_q         <= 4'b1110;
      acc_present_q <= 1'b0;
      acc_code_q    <= {KEY_CODE_W{1'b0}};
      value_q       <= 16'h0000;
    end else begin
      row_meta_q    <= row;
      row_sync_q    <= row_meta_q;
      div_q         <= div_d;
      col_idx_q     <= col_idx_d;
      col_q         <= col_d;
      acc_present_q <= acc_present_d;
      acc_code_q    <= acc_code_d;
      value_q       <= value_d;
    end
  end

  // Priority encode: the first key found in the scan (lowest column) wins,
  // otherwise the lowest low row of the column being sampled now.
  always_comb begin
    row_hit_s = ~row_sync_q;
    if (row_hit_s[0]) begin
      row_idx_s = 2'd0;
    end else if (row_hit_s[1]) begin
      row_idx_s = 2'd1;
    end else if (row_hit_s[2]) begin
      row_idx_s = 2'd2;
    end else begin
      row_idx_s = 2'd3;
    end
    carry_present_s = (col_idx_q == 2'd0) ? 1'b0 : acc_present_q;
    if (carry_present_s) begin
      present_s = 1'b1;
      code_s    = acc_code_q;
    end else if (|row_hit_s) begin
      present_s = 1'b1;
      code_s    = key_encode(row_idx_s, col_idx_q);
    end else begin
      present_s = 1'b0;
      code_s    = {KEY_CODE_W{1'b0}};
    end
  end

  // Column dwell counter; at the end of each dwell sample and move to the next column.
  always_comb begin
    div_d = div_q + DIV_ONE;
    if (sample_s) begin
      col_idx_d     = col_idx_q + 2'd1;
      col_d         = ~(4'b0001 << col_idx_d);
      acc_present_d = present_s;
      acc_code_d    = code_s;
    end else begin
      col_idx_d     = col_idx_q;
      col_d         = col_q;
      acc_present_d = acc_present_q;
      acc_code_d    = acc_code_q;
    end
  end

  // Digit entry: clear has priority over shifting in a new key.
  always_comb begin
    if (clear) begin
      value_d = 16'h0000;
    end else if (key_valid_s) begin
      value_d = {value_q[11:0], key_code_s};
    end else begin
      value_d = value_q;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i      (clk),
    .rst_i      (rst),
    .scan_end_i (scan_end_s),
    .present_i  (present_s),
    .code_i     (code_s),
    .key_valid_o(key_valid_s),
    .key_code_o (key_code_s)
  );

  assign col       = col_q;
  assign key_valid = key_valid_s;
  assign key_code  = key_code_s;
  assign value     = value_q;

endmodule
